// File: rtl/sram_pipe_pkg.sv
// Shared types and helpers for the sram_pipe block.
// SRAM_PIPE_PARITY_EN widens each stored byte lane by one even-parity bit.
package sram_pipe_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_INIT = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

`ifdef SRAM_PIPE_PARITY_EN
  localparam int unsigned LANE_W = 9;
`else
  localparam int unsigned LANE_W = 8;
`endif

  function automatic int unsigned byte_cnt(input int unsigned dw);
    return dw / 8;
  endfunction

  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sram_pipe_if.sv
// Request/response bus between a requester and sram_pipe.
interface sram_pipe_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 8
) ();
  localparam int unsigned NB = DW / 8;

  logic          req;
  logic          we;
  logic [NB-1:0] be;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          wpar_inv;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          rerr;
  logic          init_done;

  modport master (
    output req, we, be, addr, wdata, wpar_inv,
    input  gnt, rvalid, rdata, rerr, init_done
  );

  modport slave (
    input  req, we, be, addr, wdata, wpar_inv,
    output gnt, rvalid, rdata, rerr, init_done
  );
endinterface

// File: rtl/sram_pipe_array.sv
// Single-port byte-lane-masked storage: synchronous write, combinational read, no reset.
module sram_pipe_array #(
  parameter int unsigned NB = 4,
  parameter int unsigned LW = 8,
  parameter int unsigned AW = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [NB-1:0]    be,
  input  logic [AW-1:0]    addr,
  input  logic [NB*LW-1:0] wdata,
  output logic [NB*LW-1:0] rdata_c
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [NB*LW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr][i*LW +: LW] <= wdata[i*LW +: LW];
      end
    end
  end

  assign rdata_c = mem[addr];

endmodule

// File: rtl/sram_pipe.sv
// Pipelined SRAM wrapper: clears the array after reset, then serves one request per cycle.
// Optional per-byte parity under SRAM_PIPE_PARITY_EN.
module sram_pipe
  import sram_pipe_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 8,
  parameter int unsigned OUT_REG = 0
) (
  input logic        clk,
  input logic        rst,
  sram_pipe_if.slave bus
);
  localparam int unsigned NB = byte_cnt(DW);
  localparam int unsigned MW = NB * LANE_W;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q;
  logic            run_q;

  logic            mem_we;
  logic [NB-1:0]   mem_be;
  logic [AW-1:0]   mem_addr;
  logic [MW-1:0]   mem_wdata;
  logic [MW-1:0]   mem_rdata;
  logic            rd_acc;

  logic [MW-1:0]   wr_lanes;
  logic [DW-1:0]   rd_data;
  logic [NB-1:0]   rd_bad;

  logic            rd1_v;
  logic [DW-1:0]   rd1_data;
  logic            rd1_err;

  // State, clear counter and the shared gnt/init_done flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) cnt_q <= cnt_q + AW'(1);
      run_q   <= (state_d == ST_RUN);
    end
  end

  // Next state and array port steering; INIT owns the port until every word is cleared.
  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = bus.addr;
    mem_wdata = '0;
    rd_acc    = 1'b0;
    case (state_q)
      ST_INIT: begin
        mem_we   = 1'b1;
        mem_be   = '1;
        mem_addr = cnt_q;
        if (cnt_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.req) begin
          if (bus.we) begin
            mem_we    = 1'b1;
            mem_be    = bus.be;
            mem_wdata = wr_lanes;
          end else begin
            rd_acc = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  for (genvar i = 0; i < NB; i++) begin : g_lane
`ifdef SRAM_PIPE_PARITY_EN
    assign wr_lanes[i*LANE_W +: LANE_W] = {byte_par(bus.wdata[i*8 +: 8]) ^ bus.wpar_inv,
                                           bus.wdata[i*8 +: 8]};
    assign rd_bad[i] = mem_rdata[i*LANE_W + 8] ^ byte_par(mem_rdata[i*LANE_W +: 8]);
`else
    assign wr_lanes[i*LANE_W +: LANE_W] = bus.wdata[i*8 +: 8];
    assign rd_bad[i] = 1'b0;
`endif
    assign rd_data[i*8 +: 8] = mem_rdata[i*LANE_W +: 8];
  end

`ifndef SRAM_PIPE_PARITY_EN
  logic unused_wpar_inv;
  assign unused_wpar_inv = bus.wpar_inv;
`endif

  sram_pipe_array #(
    .NB (NB),
    .LW (LANE_W),
    .AW (AW)
  ) u_array (
    .clk     (clk),
    .we      (mem_we),
    .be      (mem_be),
    .addr    (mem_addr),
    .wdata   (mem_wdata),
    .rdata_c (mem_rdata)
  );

  // First read stage: data and error only load on an accepted read, so they hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1_v    <= 1'b0;
      rd1_data <= '0;
      rd1_err  <= 1'b0;
    end else begin
      rd1_v <= rd_acc;
      if (rd_acc) begin
        rd1_data <= rd_data;
        rd1_err  <= |rd_bad;
      end
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic          rd2_v;
    logic [DW-1:0] rd2_data;
    logic          rd2_err;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd2_v    <= 1'b0;
        rd2_data <= '0;
        rd2_err  <= 1'b0;
      end else begin
        rd2_v <= rd1_v;
        if (rd1_v) begin
          rd2_data <= rd1_data;
          rd2_err  <= rd1_err;
        end
      end
    end

    assign bus.rvalid = rd2_v;
    assign bus.rdata  = rd2_data;
    assign bus.rerr   = rd2_err;
  end else begin : g_noreg
    assign bus.rvalid = rd1_v;
    assign bus.rdata  = rd1_data;
    assign bus.rerr   = rd1_err;
  end

  assign bus.gnt       = run_q;
  assign bus.init_done = run_q;

endmodule

// File: tb/tb_sram_pipe.sv
// Scoreboard bench for sram_pipe: one OUT_REG=0 and one OUT_REG=1 instance share the stimulus.
module tb_sram_pipe;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
`ifdef SRAM_PIPE_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_pipe_if #(.DW(DW), .AW(AW)) bus0 ();
  sram_pipe_if #(.DW(DW), .AW(AW)) bus1 ();

  sram_pipe #(.DW(DW), .AW(AW), .OUT_REG(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sram_pipe #(.DW(DW), .AW(AW), .OUT_REG(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mdl [DEPTH];
  logic [3:0]  bad [DEPTH];
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] b,
                       input logic [3:0] a, input logic [31:0] d, input logic inv);
    bus0.req = r; bus0.we = w; bus0.be = b; bus0.addr = a; bus0.wdata = d; bus0.wpar_inv = inv;
    bus1.req = r; bus1.we = w; bus1.be = b; bus1.addr = a; bus1.wdata = d; bus1.wpar_inv = inv;
  endtask

  // One request in the next cycle; reads push the model's expectation for both latencies.
  task automatic op(input logic w, input logic [3:0] b, input logic [3:0] a,
                    input logic [31:0] d, input logic inv);
    exp_t e;
    @(negedge clk);
    drive(1'b1, w, b, a, d, inv);
    if (w) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i]) begin
          mdl[a][i*8 +: 8] = d[i*8 +: 8];
          bad[a][i]        = inv;
        end
      end
    end else begin
      e.d   = mdl[a];
      e.e   = PAR && (|bad[a]);
      e.due = cyc + 1;
      q0.push_back(e);
      e.due = cyc + 2;
      q1.push_back(e);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b, input logic inv);
    op(1'b1, b, a, d, inv);
  endtask

  task automatic rd(input logic [3:0] a);
    op(1'b0, 4'h0, a, 32'h0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
    end
  endtask

  task automatic mon(input int k, input logic rv, input logic [31:0] rdat, input logic re);
    exp_t f;
    bit   has;
    has = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
    if (has) begin
      if (k == 0) f = q0[0];
      else        f = q1[0];
    end
    if (rv) begin
      if (!has) begin
        check($sformatf("spurious_rvalid%0d", k), 32'(rv), 32'd0);
      end else begin
        if (k == 0) begin void'(q0.pop_front()); last0 = rdat; end
        else        begin void'(q1.pop_front()); last1 = rdat; end
        check($sformatf("rvalid_cycle%0d", k), 32'(cyc), 32'(f.due));
        check($sformatf("rdata%0d", k), rdat, f.d);
        check($sformatf("rerr%0d", k), 32'(re), 32'(f.e));
      end
    end else begin
      check($sformatf("rdata_hold%0d", k), rdat, (k == 0) ? last0 : last1);
      if (has && f.due <= cyc) begin
        check($sformatf("rvalid_missing%0d", k), 32'(rv), 32'd1);
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, bus0.rvalid, bus0.rdata, bus0.rerr);
      mon(1, bus1.rvalid, bus1.rdata, bus1.rerr);
    end
  end

  // Asserts reset now, checks reset outputs, then times the clearing phase with req held high.
  task automatic do_reset();
    int n;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    last0 = '0;
    last1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i] = '0;
      bad[i] = '0;
    end
    drive(1'b1, 1'b0, 4'hF, 4'h0, 32'hFFFF_FFFF, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("rst_gnt0",    32'(bus0.gnt),       32'd0);
      check("rst_gnt1",    32'(bus1.gnt),       32'd0);
      check("rst_rvalid0", 32'(bus0.rvalid),    32'd0);
      check("rst_rvalid1", 32'(bus1.rvalid),    32'd0);
      check("rst_rdata0",  bus0.rdata,          32'd0);
      check("rst_rdata1",  bus1.rdata,          32'd0);
      check("rst_rerr0",   32'(bus0.rerr),      32'd0);
      check("rst_rerr1",   32'(bus1.rerr),      32'd0);
      check("rst_done0",   32'(bus0.init_done), 32'd0);
      check("rst_done1",   32'(bus1.init_done), 32'd0);
    end
    rst = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus0.gnt && bus1.gnt) break;
    end
    drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
    check("init_cycles", 32'(n), 32'(DEPTH));
    check("init_done0", 32'(bus0.init_done), 32'd1);
    check("init_done1", 32'(bus1.init_done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    do_reset();

    for (int a = 0; a < DEPTH; a++) rd(4'(a));
    idle(3);

    wr(4'd3, 32'hDEAD_BEEF, 4'hF, 1'b0);
    wr(4'd3, 32'h1122_3344, 4'b0101, 1'b0);
    rd(4'd3);
    idle(3);

    wr(4'd5, 32'hCAFE_0005, 4'hF, 1'b0);
    idle(1);
    rd(4'd5);
    idle(3);
    repeat (4) rd(4'd5);
    idle(3);

    wr(4'd7, 32'hA5A5_A5A5, 4'hF, 1'b0);
    rd(4'd7);
    wr(4'd7, 32'hFFFF_FFFF, 4'h0, 1'b1);
    rd(4'd7);
    idle(2);

    repeat (200) begin
      if ($urandom_range(4) == 0) idle(1);
      else op(1'($urandom_range(1)), 4'($urandom), 4'($urandom), $urandom,
              1'($urandom_range(3) == 0));
    end
    for (int a = 0; a < DEPTH; a++) rd(4'(a));
    idle(3);

    wr(4'd2, 32'h1234_5678, 4'hF, 1'b0);
    wr(4'd2, 32'h0000_AB00, 4'b0010, 1'b1);
    rd(4'd2);
    wr(4'd2, 32'h0000_CD00, 4'b0010, 1'b0);
    rd(4'd2);
    idle(3);

    wr(4'd9, 32'h9999_9999, 4'hF, 1'b0);
    rd(4'd9);
    rd(4'd9);
    @(posedge clk);
    #1;
    do_reset();
    rd(4'd9);
    rd(4'd3);
    idle(5);

    check("drain0", 32'(q0.size()), 32'd0);
    check("drain1", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
